param_vending_machine: RTL
==========================

// Module: param_vending_machine
// PURPOSE
//  Parametrised vending machine with change return. Coin count, coin values, item count and
//  item prices are parameters. Adds an inactivity timeout and a return trigger that pays out the
//  balance as greedy coin change. Drop-in successor to the fixed-table simple vending machine
//  and top-level block of the vending subsystem.
// PARAMETERS
//  NUM_COINS       3                      number of coin types
//  NUM_ITEMS       4                      number of item types
//  TOTAL_BITS      31                     balance register width
//  TIMEOUT_CYCLES  100                    idle cycles before auto-return (>=1)
//  COIN_VALUES     {1000,500,100}         packed NUM_COINS x TOTAL_BITS; index 0 = LSB field; strictly ascending
//  ITEM_PRICES     {2000,1000,500,400}    packed NUM_ITEMS x TOTAL_BITS; index 0 = LSB field
// PORTS
//  clk               in   1           clock, rising edge
//  reset_n           in   1           asynchronous active-low reset
//  i_input_coin      in   NUM_COINS   one bit per coin type inserted this cycle; any combination
//  i_select_item     in   NUM_ITEMS   item request bits, sampled every cycle
//  i_trigger_return  in   1           request payout of the whole balance
//  o_available_item  out  NUM_ITEMS   combinational: bit i = (price_i <= balance) && state != RETURN
//  o_output_item     out  NUM_ITEMS   registered one-hot dispense pulse, one cycle long
//  o_return_coin     out  NUM_COINS   registered one-hot change coin, one coin per cycle
//  o_balance         out  TOTAL_BITS  current balance register
//  o_busy            out  1           1 while in RETURN
// BEHAVIOUR
//  Reset (async): state=IDLE, balance=0, timer=0. o_output_item, o_return_coin and o_busy are 0.
//  States: IDLE (balance==0), ACTIVE (balance>0), RETURN (paying out change).
//  IDLE/ACTIVE, each edge:
//   - coin_sum = sum of COIN_VALUES[i] over the set i_input_coin bits.
//   - Item select: pick the lowest index i with i_select_item[i] set and price_i <= balance (pre-edge
//     value). Drive o_output_item = 1<<i next cycle and subtract price_i. At most one item per edge;
//     unaffordable or lower-priority requests are dropped, not queued.
//   - balance_next = balance + coin_sum - price_sel. Price is checked against the pre-edge balance,
//     so coins inserted in the same cycle do not fund that cycle's purchase.
//   - Overflow: if balance + coin_sum would exceed 2^TOTAL_BITS-1, reject all coins that edge
//     (coin_sum treated as 0). The purchase still proceeds.
//   - Timer: loads TIMEOUT_CYCLES on any accepted coin or dispense. Otherwise decrements while in
//     ACTIVE.
//   - Transitions: balance_next>0 -> ACTIVE; balance_next==0 -> IDLE.
//     i_trigger_return with balance>0 -> RETURN; this overrides coins and select that edge, and
//     they are ignored.
//     Timer decrementing from 1 to 0 in ACTIVE -> RETURN.
//     i_trigger_return with balance==0: no effect.
//  RETURN, each edge:
//   - Pick the largest j with COIN_VALUES[j] <= balance. Set o_return_coin = 1<<j and
//     balance -= COIN_VALUES[j].
//   - If no coin fits (remainder below the smallest coin, including 0): o_return_coin=0,
//     balance=0, go to IDLE.
//   - Coins, select and trigger are ignored. o_available_item=0. o_busy=1.
//  Latency: a coin sampled at edge k is visible in o_balance after edge k. A dispense selected at
//   edge k produces its o_output_item pulse in cycle k..k+1. Payout of N coins occupies N edges,
//   plus one closing edge to IDLE.
//  Reset mid-RETURN or mid-purchase: immediate abort; the balance is lost.
// TESTING
//  1 Assert reset_n=0 mid-operation -> all outputs 0 asynchronously, o_balance=0, state IDLE.
//  2 coin=3'b100 (1000), next cycle select=4'b0010 -> o_output_item=4'b0010 for exactly one cycle,
//    o_balance=500, o_available_item=4'b0011.
//  3 coin=3'b011 in one cycle -> o_balance=600. Same cycle as select=4'b0001 from balance 0
//    -> no dispense.
//  4 balance=1600, i_trigger_return=1 -> o_return_coin 100, 010, 001 on successive cycles, then
//    0. o_busy high 4 cycles. o_balance=0, state IDLE.
//  5 TIMEOUT_CYCLES=8: insert 500, hold inputs idle -> RETURN entered 8 edges after the accepting
//    edge. o_return_coin=3'b010 one cycle later. Toggling select on an unaffordable item does not
//    delay the timeout.
//  6 balance=1000, select=4'b0011 -> only item0 dispensed, balance 600.
//    balance=2^31-50, coin=3'b001 -> coin rejected, balance unchanged.

Source files
------------

// File: rtl/param_vending_machine_if.sv
// Request/response bundle of the vending machine: coin, select and return inputs in,
// availability, dispense, change and balance out.
interface param_vending_machine_if #(
    parameter int NUM_COINS  = 3,
    parameter int NUM_ITEMS  = 4,
    parameter int TOTAL_BITS = 31
);
    logic [NUM_COINS-1:0]  i_input_coin;
    logic [NUM_ITEMS-1:0]  i_select_item;
    logic                  i_trigger_return;
    logic [NUM_ITEMS-1:0]  o_available_item;
    logic [NUM_ITEMS-1:0]  o_output_item;
    logic [NUM_COINS-1:0]  o_return_coin;
    logic [TOTAL_BITS-1:0] o_balance;
    logic                  o_busy;

    modport master (
        output i_input_coin, i_select_item, i_trigger_return,
        input  o_available_item, o_output_item, o_return_coin, o_balance, o_busy
    );

    modport slave (
        input  i_input_coin, i_select_item, i_trigger_return,
        output o_available_item, o_output_item, o_return_coin, o_balance, o_busy
    );
endinterface

// File: rtl/param_vending_machine.sv
// Parametrised vending machine: accumulates coins, dispenses the lowest-index affordable item,
// and pays the balance out as greedy change on request or after an inactivity timeout.
module param_vending_machine #(
    parameter int NUM_COINS      = 3,
    parameter int NUM_ITEMS      = 4,
    parameter int TOTAL_BITS     = 31,
    parameter int TIMEOUT_CYCLES = 100,
    parameter logic [NUM_COINS*TOTAL_BITS-1:0] COIN_VALUES =
        {31'd1000, 31'd500, 31'd100},
    parameter logic [NUM_ITEMS*TOTAL_BITS-1:0] ITEM_PRICES =
        {31'd2000, 31'd1000, 31'd500, 31'd400}
) (
    input logic                   clk,
    input logic                   reset_n,
    param_vending_machine_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_RETURN
    } state_t;

    localparam int TIMER_BITS = $clog2(TIMEOUT_CYCLES + 1);
    // Wide enough for balance plus every coin at once, so overflow is detectable.
    localparam int SUM_BITS   = TOTAL_BITS + $clog2(NUM_COINS + 1) + 1;

    localparam logic [SUM_BITS-1:0]   BALANCE_MAX  = SUM_BITS'({TOTAL_BITS{1'b1}});
    localparam logic [TIMER_BITS-1:0] TIMER_RELOAD = TIMER_BITS'(TIMEOUT_CYCLES);
    localparam logic [TIMER_BITS-1:0] TIMER_LAST   = TIMER_BITS'(1);

    function automatic logic [TOTAL_BITS-1:0] coin_value(input int idx);
        return COIN_VALUES[idx*TOTAL_BITS +: TOTAL_BITS];
    endfunction

    function automatic logic [TOTAL_BITS-1:0] item_price(input int idx);
        return ITEM_PRICES[idx*TOTAL_BITS +: TOTAL_BITS];
    endfunction

    state_t                state_q, state_d;
    logic [TOTAL_BITS-1:0] balance_q, balance_d;
    logic [TIMER_BITS-1:0] timer_q, timer_d;
    logic [NUM_ITEMS-1:0]  item_q, item_d;
    logic [NUM_COINS-1:0]  coin_q, coin_d;

    logic [SUM_BITS-1:0]   coin_sum;
    logic [SUM_BITS-1:0]   balance_wide;
    logic                  coin_ok;
    logic                  sel_found;
    logic [TOTAL_BITS-1:0] sel_price;
    logic [NUM_ITEMS-1:0]  sel_onehot;
    logic                  change_found;
    logic [TOTAL_BITS-1:0] change_value;
    logic [NUM_COINS-1:0]  change_onehot;

    // NOTE: every signal assigned in an always_comb gets a default at the top of the block;
    // a path that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        coin_sum      = '0;
        sel_found     = 1'b0;
        sel_price     = '0;
        sel_onehot    = '0;
        change_found  = 1'b0;
        change_value  = '0;
        change_onehot = '0;

        for (int i = 0; i < NUM_COINS; i++) begin
            if (bus.i_input_coin[i]) begin
                coin_sum = coin_sum + SUM_BITS'(coin_value(i));
            end
        end

        // Descending scan so the lowest affordable index is the one left standing.
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (bus.i_select_item[i] && (item_price(i) <= balance_q)) begin
                sel_found  = 1'b1;
                sel_price  = item_price(i);
                sel_onehot = NUM_ITEMS'(1) << i;
            end
        end

        // Ascending scan over ascending coin values leaves the largest coin that fits.
        for (int j = 0; j < NUM_COINS; j++) begin
            if (coin_value(j) <= balance_q) begin
                change_found  = 1'b1;
                change_value  = coin_value(j);
                change_onehot = NUM_COINS'(1) << j;
            end
        end
    end

    assign balance_wide = SUM_BITS'(balance_q) + coin_sum;
    assign coin_ok      = (|bus.i_input_coin) && (balance_wide <= BALANCE_MAX);

    always_comb begin
        state_d   = state_q;
        balance_d = balance_q;
        timer_d   = timer_q;
        item_d    = '0;
        coin_d    = '0;

        unique case (state_q)
            S_IDLE, S_ACTIVE: begin
                if (bus.i_trigger_return && (balance_q != '0)) begin
                    state_d = S_RETURN;
                    timer_d = '0;
                end else begin
                    // Purchase is funded only by the pre-edge balance; rejected coins add nothing.
                    balance_d = (coin_ok ? balance_wide[TOTAL_BITS-1:0] : balance_q) - sel_price;
                    item_d    = sel_onehot;
                    if (coin_ok || sel_found) begin
                        timer_d = TIMER_RELOAD;
                    end else if ((state_q == S_ACTIVE) && (timer_q != '0)) begin
                        timer_d = timer_q - 1'b1;
                    end

                    if ((state_q == S_ACTIVE) && !coin_ok && !sel_found && (timer_q == TIMER_LAST)) begin
                        state_d = S_RETURN;
                    end else begin
                        state_d = (balance_d != '0) ? S_ACTIVE : S_IDLE;
                    end
                end
            end

            S_RETURN: begin
                if (change_found) begin
                    coin_d    = change_onehot;
                    balance_d = balance_q - change_value;
                end else begin
                    balance_d = '0;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d   = S_IDLE;
                balance_d = '0;
                timer_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            balance_q <= '0;
            timer_q   <= '0;
            item_q    <= '0;
            coin_q    <= '0;
        end else begin
            state_q   <= state_d;
            balance_q <= balance_d;
            timer_q   <= timer_d;
            item_q    <= item_d;
            coin_q    <= coin_d;
        end
    end

    always_comb begin
        bus.o_available_item = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            bus.o_available_item[i] = (item_price(i) <= balance_q) && (state_q != S_RETURN);
        end
    end

    assign bus.o_output_item = item_q;
    assign bus.o_return_coin = coin_q;
    assign bus.o_balance     = balance_q;
    assign bus.o_busy        = (state_q == S_RETURN);

endmodule
